// File: rtl/seg7_scan_if.sv
// seg7_scan_if: control and display bus for seg7_scan_driver; SEG7_BLINK_EN adds blink_mask
interface seg7_scan_if #(parameter int NUM_DIGITS = 4);
  logic en;
  logic load;
  logic [NUM_DIGITS*5-1:0] char_in;
  logic [NUM_DIGITS-1:0] blank_mask;
`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_mask;
`endif
  logic [6:0] seg_out;
  logic [NUM_DIGITS-1:0] an_out;
  logic frame_start;
  modport master (
`ifdef SEG7_BLINK_EN
    output blink_mask,
`endif
    output en, load, char_in, blank_mask,
    input seg_out, an_out, frame_start
  );
  modport slave (
`ifdef SEG7_BLINK_EN
    input blink_mask,
`endif
    input en, load, char_in, blank_mask,
    output seg_out, an_out, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment driver with frame-coherent double buffer
// Optional per-digit blinking is enabled with the SEG7_BLINK_EN macro.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 32
`endif
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_if.slave bus
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int W = NUM_DIGITS * 5;
  localparam logic [6:0] SOFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AOFF = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  logic [PW-1:0] p;
  logic [DW-1:0] d;
  logic [W-1:0] active, pending;
  logic pend_valid;
  logic [6:0] seg_q, glyph;
  logic [NUM_DIGITS-1:0] an_q, an_on;
  logic fs_q, slot_end, frame_end, lit, hide;
  logic [4:0] code;
  function automatic logic [6:0] glyph_of(input logic [4:0] c);
    case (c)
      5'd0: glyph_of = 7'h3F;
      5'd1: glyph_of = 7'h06;
      5'd2: glyph_of = 7'h5B;
      5'd3: glyph_of = 7'h4F;
      5'd4: glyph_of = 7'h66;
      5'd5: glyph_of = 7'h6D;
      5'd6: glyph_of = 7'h7D;
      5'd7: glyph_of = 7'h07;
      5'd8: glyph_of = 7'h7F;
      5'd9: glyph_of = 7'h6F;
      5'd10: glyph_of = 7'h77;
      5'd11: glyph_of = 7'h7C;
      5'd12: glyph_of = 7'h39;
      5'd13: glyph_of = 7'h5E;
      5'd14: glyph_of = 7'h79;
      5'd15: glyph_of = 7'h71;
      5'd16: glyph_of = 7'h76;
      5'd17: glyph_of = 7'h1E;
      5'd18: glyph_of = 7'h38;
      5'd19: glyph_of = 7'h73;
      5'd20: glyph_of = 7'h3E;
      5'd21: glyph_of = 7'h40;
      5'd22: glyph_of = 7'h50;
      5'd23: glyph_of = 7'h5C;
      default: glyph_of = 7'h00;
    endcase
  endfunction
  assign slot_end = p == PW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && d == DW'(NUM_DIGITS - 1);
  assign lit = bus.en && p >= PW'(DEAD_CYCLES);
  assign code = active[5*int'(d) +: 5];
`ifdef SEG7_BLINK_EN
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] bcnt;
  logic phase;
  always_ff @(posedge clk)
    if (!rst_n || !bus.en) begin
      bcnt <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      bcnt <= bcnt == BW'(BLINK_FRAMES - 1) ? '0 : bcnt + 1'b1;
      if (bcnt == BW'(BLINK_FRAMES - 1)) phase <= ~phase;
    end
  assign hide = bus.blank_mask[d] || (phase && bus.blink_mask[d]);
`else
  assign hide = bus.blank_mask[d];
`endif
  assign glyph = lit && !hide ? glyph_of(code) : 7'h00;
  assign an_on = lit ? NUM_DIGITS'(1) << d : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      p <= '0;
      d <= '0;
      active <= '1;
      pending <= '1;
      pend_valid <= 1'b0;
      seg_q <= SOFF;
      an_q <= AOFF;
      fs_q <= 1'b0;
    end else begin
      p <= !bus.en || slot_end ? '0 : p + 1'b1;
      if (!bus.en) d <= '0;
      else if (slot_end) d <= d == DW'(NUM_DIGITS - 1) ? '0 : d + 1'b1;
      // a load while dark or at frame end goes live at once, superseding any pending value
      if (!bus.en || frame_end) begin
        if (bus.load) active <= bus.char_in;
        else if (bus.en && pend_valid) active <= pending;
        if (bus.load || bus.en) pend_valid <= 1'b0;
      end else if (bus.load) begin
        pending <= bus.char_in;
        pend_valid <= 1'b1;
      end
      seg_q <= glyph ^ SOFF;
      an_q <= an_on ^ AOFF;
      fs_q <= bus.en && p == '0 && d == '0;
    end
  assign bus.seg_out = seg_q;
  assign bus.an_out = an_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table vectors, corner sequences and random stimulus against a frame-position model
module tb_seg7_scan_driver;
  localparam int N = 4, R = 8, D = 2, BF = 2, FR = N * R;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic clk = 1'b0, rst_n, en, load;
  logic [N*5-1:0] char_in;
  logic [N-1:0] blank_mask, blink_mask;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  seg7_scan_if #(.NUM_DIGITS(N)) ih ();
  seg7_scan_if #(.NUM_DIGITS(N)) il ();
  assign ih.en = en;
  assign ih.load = load;
  assign ih.char_in = char_in;
  assign ih.blank_mask = blank_mask;
  assign il.en = en;
  assign il.load = load;
  assign il.char_in = char_in;
  assign il.blank_mask = blank_mask;
`ifdef SEG7_BLINK_EN
  assign ih.blink_mask = blink_mask;
  assign il.blink_mask = blink_mask;
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .SEG_ACTIVE_LOW(1'b0), .BLINK_FRAMES(BF))
    dut_h (.clk(clk), .rst_n(rst_n), .bus(ih.slave));
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .SEG_ACTIVE_LOW(1'b1), .BLINK_FRAMES(BF))
    dut_l (.clk(clk), .rst_n(rst_n), .bus(il.slave));
`else
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .SEG_ACTIVE_LOW(1'b0))
    dut_h (.clk(clk), .rst_n(rst_n), .bus(ih.slave));
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .SEG_ACTIVE_LOW(1'b1))
    dut_l (.clk(clk), .rst_n(rst_n), .bus(il.slave));
`endif
  logic [6:0] gt [32];
  logic [4:0] act [N], pend [N];
  bit pv, ph;
  int pos, bcnt;
  logic [6:0] e_seg;
  logic [N-1:0] e_an;
  logic e_fs;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  // model walks a flat frame position; slot and sub-slot come from division
  task automatic step();
    int s, p;
    bit fe;
    if (!rst_n) begin
      e_seg = '0; e_an = '0; e_fs = 1'b0;
      pos = 0; pv = 0; ph = 0; bcnt = 0;
      for (int k = 0; k < N; k++) begin act[k] = 5'd31; pend[k] = 5'd31; end
    end else begin
      s = pos / R; p = pos % R;
      fe = en && pos == FR - 1;
      e_an = (en && p >= D) ? N'(1 << s) : '0;
      e_seg = (en && p >= D && !blank_mask[s] && !(ph && blink_mask[s])) ? gt[act[s]] : 7'h00;
      e_fs = en && pos == 0;
      if (!en || (load && fe)) begin
        if (load) begin
          for (int k = 0; k < N; k++) act[k] = char_in[5*k +: 5];
          pv = 0;
        end
      end else begin
        if (fe && pv) begin act = pend; pv = 0; end
        if (load) begin
          for (int k = 0; k < N; k++) pend[k] = char_in[5*k +: 5];
          pv = 1;
        end
      end
      if (!en) begin bcnt = 0; ph = 0; end
      else if (fe && BLINK) begin
        bcnt++;
        if (bcnt == BF) begin bcnt = 0; ph = !ph; end
      end
      pos = en ? (pos + 1) % FR : 0;
    end
    @(posedge clk);
    #1;
    chk("out_hi", {ih.seg_out, ih.an_out, ih.frame_start}, {e_seg, e_an, e_fs});
    chk("out_lo", {il.seg_out, il.an_out, il.frame_start}, {~e_seg, ~e_an, e_fs});
  endtask
  typedef struct packed {
    logic [N*5-1:0] chars;
    logic [N-1:0] bm;
    logic [27:0] segs;
  } vec_t;
  vec_t vt [5];
  function automatic logic [N*5-1:0] all_code(input logic [4:0] c);
    return {c, c, c, c};
  endfunction
  initial begin
    gt = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
           7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h76, 7'h1E, 7'h38, 7'h73,
           7'h3E, 7'h40, 7'h50, 7'h5C, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    vt[0] = '{{5'd1, 5'd2, 5'd3, 5'd4}, 4'b0000, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vt[1] = '{{5'd8, 5'd8, 5'd8, 5'd8}, 4'b0100, {7'h7F, 7'h00, 7'h7F, 7'h7F}};
    vt[2] = '{{5'd10, 5'd11, 5'd12, 5'd13}, 4'b0000, {7'h77, 7'h7C, 7'h39, 7'h5E}};
    vt[3] = '{{5'd24, 5'd21, 5'd22, 5'd23}, 4'b0000, {7'h00, 7'h40, 7'h50, 7'h5C}};
    vt[4] = '{{5'd17, 5'd18, 5'd19, 5'd20}, 4'b1001, {7'h00, 7'h38, 7'h73, 7'h00}};
    rst_n = 1'b0; en = 1'b0; load = 1'b0; char_in = '0; blank_mask = '0; blink_mask = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    for (int v = 0; v < 5; v++) begin
      en = 1'b0; load = 1'b1; char_in = vt[v].chars; blank_mask = vt[v].bm;
      step();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < FR; k++) begin
        step();
        chk("tbl_fs", ih.frame_start, k == 0);
        chk("tbl_an", ih.an_out, (k % R >= D) ? N'(1 << (k / R)) : '0);
        if (k % R >= D) chk("tbl_seg", ih.seg_out, vt[v].segs[7*(k/R) +: 7]);
      end
    end
    en = 1'b0; load = 1'b1; char_in = {5'd1, 5'd2, 5'd3, 5'd4}; blank_mask = '0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 2 * FR; k++) begin
      load = k == R + 3;
      char_in = all_code(5'd16);
      step();
      if (k == 2 * R + D) chk("mid_keep2", ih.seg_out, 7'h5B);
      if (k == 3 * R + D) chk("mid_keep3", ih.seg_out, 7'h06);
      if (k == FR) chk("mid_fs", ih.frame_start, 1'b1);
      if (k == FR + D) chk("mid_new0", ih.seg_out, 7'h76);
      if (k == FR + R + D) chk("mid_new1", ih.seg_out, 7'h76);
    end
    load = 1'b0;
    for (int k = 0; k < 3 * FR; k++) begin
      load = k == 5 || k == FR - 1;
      char_in = k == 5 ? all_code(5'd5) : all_code(5'd9);
      step();
      if (k == 3 * R + D) chk("fe_old", ih.seg_out, 7'h76);
      if (k == FR + D) chk("fe_direct", ih.seg_out, 7'h6F);
      if (k == 2 * FR + D) chk("fe_noreplay", ih.seg_out, 7'h6F);
    end
    load = 1'b0;
    for (int k = 0; k < R + 4; k++) step();
    rst_n = 1'b0;
    step();
    chk("rst_lo", {il.seg_out, il.an_out, il.frame_start}, {7'h7F, 4'hF, 1'b0});
    chk("rst_hi", {ih.seg_out, ih.an_out, ih.frame_start}, 12'h000);
    rst_n = 1'b1;
    step();
    chk("restart_fs", il.frame_start, 1'b1);
    for (int k = 0; k < D; k++) step();
    chk("restart_d0", il.an_out, 4'b1110);
    en = 1'b0;
    step(); step();
    chk("dark_an", ih.an_out, 4'b0000);
    en = 1'b1;
    step();
    chk("rise_fs", ih.frame_start, 1'b1);
`ifdef SEG7_BLINK_EN
    en = 1'b0; load = 1'b1; char_in = all_code(5'd8); blink_mask = 4'b0001;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 8 * FR; k++) begin
      step();
      if (k % FR == D) chk("blink_d0", ih.seg_out, ((k / FR) % 4 >= 2) ? 7'h00 : 7'h7F);
      if (k % FR == D) chk("blink_an", ih.an_out, 4'b0001);
      if (k % FR == R + D) chk("blink_d1", ih.seg_out, 7'h7F);
    end
`endif
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      en = $urandom_range(0, 24) != 0;
      load = $urandom_range(0, 11) == 0;
      char_in = N*5'($urandom);
      if ($urandom_range(0, 63) == 0) blank_mask = N'($urandom);
      if (BLINK && $urandom_range(0, 63) == 0) blink_mask = N'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It holds a 5-bit character code per digit and maps each code through a 32-entry glyph table covering hex digits, extra letters and blank. Digits are scanned one at a time, with a programmable dead time between them. Display updates are frame-coherent, so a new value never appears on some digits of a frame and not others.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= DEAD_CYCLES+1)
DEAD_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting)
SEG_ACTIVE_LOW, 0, 1 = seg_out and an_out active-low; 0 = active-high

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  synchronous active-low reset, sampled on rising clk
en  in  1  1 = scanning; 0 = display dark, counters held at 0
load  in  1  capture char_in this cycle
char_in  in  NUM_DIGITS*5  digit k code at [5k+4:5k]; digit 0 is rightmost
blank_mask  in  NUM_DIGITS  1 = force digit k blank (applied live, not double-buffered)
seg_out  out  7  segments; bit0=a .. bit6=g, registered
an_out  out  NUM_DIGITS  one-hot digit enable, registered
frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler p=0; digit index d=0.
  - active and pending registers = code 31 (blank); pend_valid=0.
  - seg_out, an_out and frame_start all inactive (0, or all-ones if SEG_ACTIVE_LOW for seg/an).
  - Reset mid-frame aborts the frame immediately.
- Glyph map (active-high values):
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F.
  - 10 A 77, 11 b 7C, 12 C 39, 13 d 5E, 14 E 79, 15 F 71.
  - 16 H 76, 17 J 1E, 18 L 38, 19 P 73, 20 U 3E, 21 '-' 40, 22 r 50, 23 o 5C.
  - 24..31 blank 00.
  - SEG_ACTIVE_LOW inverts the final output only.
- Scan, with en=1:
  - p increments every clk; at p=REFRESH_DIV-1, p wraps to 0 and d increments.
  - d wraps from NUM_DIGITS-1 to 0.
- Output register (1-cycle latency from state {p,d}):
  - an_out = onehot(d) if p>=DEAD_CYCLES, else none.
  - seg_out = glyph(active[d]) if p>=DEAD_CYCLES and !blank_mask[d], else 0.
  - frame_start = 1 for exactly the cycle after state p=0,d=0.
- en=0:
  - p and d are forced to 0 on the next edge.
  - Outputs go inactive on the following edge; frame_start=0.
  - When en rises, scan starts at d=0, p=0, and the first frame_start is asserted.
- Load / double buffer:
  - load=1 with en=1: pending<=char_in, pend_valid<=1.
  - Frame end is the cycle with p=REFRESH_DIV-1 and d=NUM_DIGITS-1. At frame end, if pend_valid then active<=pending and pend_valid<=0.
  - load during the frame-end cycle: char_in goes directly to active; pend_valid<=0.
  - Repeated loads within a frame: last one wins.
  - load=1 with en=0: active<=char_in immediately (no frame in progress).
- Widths:
  - p is ceil(log2(REFRESH_DIV)) bits; d is ceil(log2(NUM_DIGITS)) bits, minimum 1.
  - NUM_DIGITS=1: d stays at 0 and every slot end is a frame end.

Optional Feature:
Macro SEG7_BLINK_EN.
- Defined:
  - Adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 32).
  - A frame counter toggles blink phase every BLINK_FRAMES frame ends.
  - While phase=1, digits with blink_mask[k]=1 output blank segments; an_out is unchanged.
  - Phase and counter reset to 0 on rst_n=0 or when en=0.
- Undefined: no port or parameter is added, and no digit ever blinks.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2. Reset, then en=1, load char_in={5'd1,5'd2,5'd3,5'd4} while dark (en=0 first).
   - Expect an_out 0001 with seg 66 for slot cycles 2..7.
   - Then 0010/4F, 0100/5B, 1000/06.
   - frame_start every 32 cycles.
2. Mid-frame load of code 16 (H) on all digits while d=1.
   - Digits 1..3 keep old glyphs for the rest of the frame.
   - From the next frame_start, all digits show 76.
3. load asserted exactly at frame end (p=7, d=3).
   - New data is visible on digit 0 in the very next slot.
   - pend_valid ends at 0.
4. blank_mask=0100 with code 8 on all digits.
   - Digit 2 slot: an_out=0100, seg=00.
   - Other digits: seg=7F.
   - Dead cycles have an_out=0000 everywhere.
5. SEG_ACTIVE_LOW=1, rst_n pulsed low mid-slot.
   - Next edge: seg_out=7F, an_out=1111, frame_start=0.
   - After release, scan restarts at d=0.
6. With SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=0001.
   - Digit 0 is blank in frames 2-3 and 6-7, and shown in frames 0-1 and 4-5.
   - Other digits are unaffected.
